// File: rtl/regfile_reader.sv
// regfile_reader: walks a wrap-around range of reg_file addresses and
// streams each word, tagged with its address, over a valid/ready port.
module regfile_reader #(
    parameter int NUM_REGS = 16,
    parameter int SIZE     = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [SIZE-1:0]   rd_data,
    output logic [SIZE-1:0]   out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [SIZE-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;

    // The output slot can take a new word when empty or being drained.
    assign load = !out_valid_q || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (load && remaining_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d   = first_addr;
                    // Saturate so no register is read twice in one run.
                    remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                if (load) begin
                    if (remaining_q != '0) begin
                        out_data_d  = rd_data;
                        out_addr_d  = rd_addr_q;
                        out_valid_d = 1'b1;
                        rd_addr_d   = (rd_addr_q == LAST_ADDR) ? '0
                                    : rd_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q   <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;

endmodule
